// File: rtl/pattern_cmd_gen_if.sv
// Host command FIFO read port: byte data, active-low empty flag and active-low read strobe.
interface pattern_cmd_gen_if;
  logic [7:0] disp_cmd_in;
  logic       nef;
  logic       disp_cmd_rd;

  modport master (input disp_cmd_in, input nef, output disp_cmd_rd);
  modport slave  (output disp_cmd_in, output nef, input disp_cmd_rd);
endinterface

// File: rtl/pattern_cmd_gen.sv
// Command-driven test pattern generator: reads byte commands from the host FIFO and renders
// solid/grid/checker/bar patterns from the sync generator's counters with one cycle of latency.
module pattern_cmd_gen #(
  parameter int unsigned COLOR_BITS      = 4,
  parameter int unsigned COUNT_W         = 16,
  parameter int unsigned CELL_W_LOG2     = 4,
  parameter int unsigned CELL_H_LOG2     = 4,
  parameter int unsigned BAR_SHIFT       = 7,
  parameter int unsigned RD_GAP          = 2,
  parameter bit          COMMIT_ON_FRAME = 1'b1
) (
  input  logic                  clk,
  input  logic                  nrst,
  pattern_cmd_gen_if.master     fifo,
  input  logic [COUNT_W-1:0]    hcount,
  input  logic [COUNT_W-1:0]    vcount,
  input  logic                  vis,
  output logic [COLOR_BITS-1:0] red,
  output logic [COLOR_BITS-1:0] green,
  output logic [COLOR_BITS-1:0] blue,
  output logic                  cmd_err,
  output logic [1:0]            mode
);

  localparam int unsigned GAP_W = (RD_GAP > 0) ? $clog2(RD_GAP + 1) : 1;
  localparam logic [3:0][11:0] PAL_RST = {12'hFFF, 12'hF0F, 12'h0F0, 12'h00F};

  typedef enum logic [1:0] {IDLE, STROBE, LATCH} rd_state_t;

  rd_state_t        state, state_nx;
  logic [GAP_W-1:0] gap;
  logic             rd_c;

  logic [1:0]       byte_cnt;
  logic [2:0]       op_q;
  logic [7:0]       d1;

  logic [1:0]       sh_mode;
  logic [3:0]       sh_v_off, sh_h_off, lv_v_off, lv_h_off;
  logic [3:0][11:0] sh_pal, lv_pal;

  logic             commit;
  logic [1:0]       pal_idx;
  logic [11:0]      color;
  logic             unused_bits;

  // Read FSM
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state <= IDLE;
      gap   <= '0;
    end else begin
      state <= state_nx;
      if (state == LATCH)
        gap <= GAP_W'(RD_GAP);
      else if (gap != '0)
        gap <= gap - GAP_W'(1);
    end
  end

  always_comb begin
    state_nx = state;
    rd_c     = 1'b1;
    case (state)
      IDLE:    if (fifo.nef && gap == '0) state_nx = STROBE;
      STROBE:  begin
                 rd_c     = 1'b0;
                 state_nx = LATCH;
               end
      LATCH:   state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  assign fifo.disp_cmd_rd = rd_c;

  // Command decoder; the FIFO byte is valid at the end of LATCH
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      byte_cnt <= '0;
      op_q     <= '0;
      d1       <= '0;
      cmd_err  <= 1'b0;
      sh_mode  <= 2'd1;
      sh_v_off <= 4'd2;
      sh_h_off <= 4'd0;
      sh_pal   <= PAL_RST;
    end else begin
      cmd_err <= 1'b0;
      if (state == LATCH) begin
        case (byte_cnt)
          2'd0: begin
            case (fifo.disp_cmd_in)
              8'h00: ;
              8'h01, 8'h02, 8'h04, 8'h05, 8'h06, 8'h07: begin
                op_q     <= fifo.disp_cmd_in[2:0];
                byte_cnt <= 2'd1;
              end
              default: cmd_err <= 1'b1;
            endcase
          end
          2'd1: begin
            case (op_q)
              3'b001: begin
                sh_mode  <= fifo.disp_cmd_in[1:0];
                byte_cnt <= 2'd0;
              end
              3'b010: begin
                sh_v_off <= fifo.disp_cmd_in[7:4];
                sh_h_off <= fifo.disp_cmd_in[3:0];
                byte_cnt <= 2'd0;
              end
              default: begin
                d1       <= fifo.disp_cmd_in;
                byte_cnt <= 2'd2;
              end
            endcase
          end
          default: begin
            sh_pal[op_q[1:0]] <= {d1, fifo.disp_cmd_in[3:0]};
            byte_cnt          <= 2'd0;
          end
        endcase
      end
    end
  end

  // Without frame commit the live set simply trails the shadow set by one cycle
  assign commit = !COMMIT_ON_FRAME || (hcount == '0 && vcount == '0);

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      mode     <= 2'd1;
      lv_v_off <= 4'd2;
      lv_h_off <= 4'd0;
      lv_pal   <= PAL_RST;
    end else if (commit) begin
      mode     <= sh_mode;
      lv_v_off <= sh_v_off;
      lv_h_off <= sh_h_off;
      lv_pal   <= sh_pal;
    end
  end

  // Pixel path
  always_comb begin
    pal_idx = 2'd0;
    case (mode)
      2'd0: pal_idx = 2'd0;
      2'd1: begin
        if (vcount[CELL_H_LOG2-1:0] == lv_v_off[CELL_H_LOG2-1:0])
          pal_idx = 2'd1;
        else if (hcount[CELL_W_LOG2-1:0] == lv_h_off[CELL_W_LOG2-1:0])
          pal_idx = 2'd2;
      end
      2'd2:    pal_idx = {1'b0, hcount[CELL_W_LOG2] ^ vcount[CELL_H_LOG2]};
      default: pal_idx = hcount[BAR_SHIFT+1:BAR_SHIFT];
    endcase
  end

  assign color = lv_pal[pal_idx];

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else if (!vis) begin
      red   <= '0;
      green <= '0;
      blue  <= '0;
    end else begin
      red   <= color[11 -: COLOR_BITS];
      green <= color[7 -: COLOR_BITS];
      blue  <= color[3 -: COLOR_BITS];
    end
  end

  assign unused_bits = &{1'b0, hcount, vcount, lv_v_off, lv_h_off, color};

endmodule
